// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: FSM state encoding and
// operation select codes.
package calc_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ENTRY = 2'b01,
      S_OPER  = 2'b11
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic logic state_is_legal(input logic [1:0] code);
      return (code == S_IDLE) || (code == S_ENTRY) || (code == S_OPER);
   endfunction

endpackage

// File: rtl/calc_seq_unit_if.sv
// Button, keypad and display-driver signals of the calculator sequencer.
interface calc_seq_unit_if #(
   parameter int WIDTH = 8
);
   logic             enter;
   logic             number;
   logic             total;
   logic             clear;
   logic             valid;
   logic             op;
   logic [WIDTH-1:0] data_in;
   logic             store;
   logic             update;
   logic             clr;
   logic             show;
   logic             ovf;
   logic [1:0]       state;
   logic [WIDTH-1:0] display;

   modport master (
      output enter, number, total, clear, valid, op, data_in,
      input  store, update, clr, show, ovf, state, display
   );

   modport slave (
      input  enter, number, total, clear, valid, op, data_in,
      output store, update, clr, show, ovf, state, display
   );
endinterface

// File: rtl/btn_edge.sv
// Registers one button level and flags its rising edge for the current cycle.
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = level;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign pulse = level & ~prev_q;

endmodule

// File: rtl/calc_seq_unit.sv
// Calculator sequencer: button edge events drive the IDLE/ENTRY/OPER FSM,
// the accumulator/operand datapath and the display-driver strobes.
//
//  state   | meaning
//  --------+------------------------------------------------
//  S_IDLE  | cleared, waiting for the first entered value
//  S_ENTRY | acc holds a value, waiting for an operand
//  S_OPER  | operand captured, next enter applies the op
//  2'b10   | illegal, forced back to S_IDLE on the next clock
module calc_seq_unit
   import calc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit SAT   = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   calc_seq_unit_if.slave bus
);

   logic ev_enter;
   logic ev_number;
   logic ev_total;
   logic ev_clear;

   btn_edge u_enter  (.clk(clk), .reset(reset), .level(bus.enter),  .pulse(ev_enter));
   btn_edge u_number (.clk(clk), .reset(reset), .level(bus.number), .pulse(ev_number));
   btn_edge u_total  (.clk(clk), .reset(reset), .level(bus.total),  .pulse(ev_total));
   btn_edge u_clear  (.clk(clk), .reset(reset), .level(bus.clear),  .pulse(ev_clear));

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             show_q, show_d;
   logic             ovf_q, ovf_d;
   logic             store_q, store_d;
   logic             update_q, update_d;
   logic             clr_q, clr_d;

   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic [WIDTH-1:0] arith_res;
   logic             arith_ovf;

   // The extra top bit of each result is the carry (add) or borrow (sub).
   always_comb begin
      sum_w  = {1'b0, acc_q} + {1'b0, opnd_q};
      diff_w = {1'b0, acc_q} - {1'b0, opnd_q};
      if (bus.op == OP_SUB) begin
         arith_ovf = diff_w[WIDTH];
         arith_res = (SAT && arith_ovf) ? '0 : diff_w[WIDTH-1:0];
      end else begin
         arith_ovf = sum_w[WIDTH];
         arith_res = (SAT && arith_ovf) ? '1 : sum_w[WIDTH-1:0];
      end
   end

   always_comb begin
      state_d  = state_is_legal(state_q) ? state_q : S_IDLE;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      show_d   = show_q;
      ovf_d    = ovf_q;
      store_d  = 1'b0;
      update_d = 1'b0;
      clr_d    = 1'b0;

      // One event per cycle; an enter without valid still takes its slot.
      if (ev_clear) begin
         state_d = S_IDLE;
         acc_d   = '0;
         opnd_d  = '0;
         show_d  = 1'b0;
         ovf_d   = 1'b0;
         clr_d   = 1'b1;
      end else if (ev_enter) begin
         if (bus.valid) begin
            case (state_q)
               S_IDLE, S_ENTRY: begin
                  acc_d   = bus.data_in;
                  store_d = 1'b1;
                  state_d = S_ENTRY;
               end
               S_OPER: begin
                  acc_d    = arith_res;
                  ovf_d    = ovf_q | arith_ovf;
                  update_d = 1'b1;
                  state_d  = S_ENTRY;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end else if (ev_number) begin
         if (state_q == S_ENTRY) begin
            opnd_d  = bus.data_in;
            state_d = S_OPER;
         end
      end else if (ev_total) begin
         show_d = ~show_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         opnd_q   <= '0;
         show_q   <= 1'b0;
         ovf_q    <= 1'b0;
         store_q  <= 1'b0;
         update_q <= 1'b0;
         clr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         show_q   <= show_d;
         ovf_q    <= ovf_d;
         store_q  <= store_d;
         update_q <= update_d;
         clr_q    <= clr_d;
      end
   end

   assign bus.store   = store_q;
   assign bus.update  = update_q;
   assign bus.clr     = clr_q;
   assign bus.show    = show_q;
   assign bus.ovf     = ovf_q;
   assign bus.state   = state_q;
   assign bus.display = show_q ? acc_q : opnd_q;

endmodule
